// File: rtl/comp_inhibit_if.sv
// Phrase-level handshake and control bundle between the data comparator, the
// inhibit stage and the destination write path.
interface comp_inhibit_if;
  logic [7:0] dcomp;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] pixsize;
  logic       dcompen;
  logic       phrase_mode;
  logic [2:0] pixa;
  logic [7:0] dbinh;
  logic       inhibit;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output dcomp, in_valid, pixsize, dcompen, phrase_mode, pixa, out_ready,
    input  in_ready, dbinh, inhibit, out_valid
  );

  modport slave (
    input  dcomp, in_valid, pixsize, dcompen, phrase_mode, pixa, out_ready,
    output in_ready, dbinh, inhibit, out_valid
  );
endinterface

// File: rtl/comp_inhibit.sv
// Registered compare-inhibit stage: folds byte equality flags into per-pixel
// matches and produces the byte write-inhibit mask behind a one-entry buffer.
module comp_inhibit #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  comp_inhibit_if.slave    bus,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] inh_cnt
);

  // A lane matches only when every byte of its pixel matched.
  function automatic logic [7:0] fold_eq(input logic [2:0] ps, input logic [7:0] dc);
    logic [7:0] r;
    r = 8'h00;
    case (ps)
      3'd3: r = dc;
      3'd4: begin
        for (int j = 0; j < 4; j++) begin
          r[2*j]   = dc[2*j] & dc[2*j+1];
          r[2*j+1] = dc[2*j] & dc[2*j+1];
        end
      end
      3'd5: begin
        r[3:0] = {4{&dc[3:0]}};
        r[7:4] = {4{&dc[7:4]}};
      end
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sel_lanes(input logic [2:0] ps, input logic [2:0] pa);
    logic [7:0] r;
    r = 8'h00;
    case (ps)
      3'd3:    r = 8'h01 << pa;
      3'd4:    r = 8'h03 << {pa[1:0], 1'b0};
      3'd5:    r = pa[0] ? 8'hF0 : 8'h0F;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  logic [7:0]       dbinh_q, dbinh_d;
  logic             inhibit_q, inhibit_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_s;
  logic             accept_s;
  logic [7:0]       cmpmask_s;
  logic [7:0]       selmask_s;
  logic [7:0]       res_s;

  always_comb begin
    in_ready_s = ~out_valid_q | bus.out_ready;
    accept_s   = bus.in_valid & in_ready_s;
    cmpmask_s  = bus.dcompen ? fold_eq(bus.pixsize, bus.dcomp) : 8'h00;
    selmask_s  = sel_lanes(bus.pixsize, bus.pixa);
    if (bus.phrase_mode) begin
      res_s = cmpmask_s;
    end else begin
      res_s = ~selmask_s | (cmpmask_s & selmask_s);
    end
  end

  // Next-state for the output buffer and the saturating event counter.
  always_comb begin
    dbinh_d     = dbinh_q;
    inhibit_d   = inhibit_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (accept_s) begin
      dbinh_d     = res_s;
      inhibit_d   = (res_s == 8'hFF);
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (cnt_clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (accept_s && (res_s == 8'hFF) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      dbinh_q     <= 8'h00;
      inhibit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      dbinh_q     <= dbinh_d;
      inhibit_q   <= inhibit_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.dbinh     = dbinh_q;
  assign bus.inhibit   = inhibit_q;
  assign bus.out_valid = out_valid_q;
  assign inh_cnt       = cnt_q;

endmodule

// File: tb/tb_comp_inhibit.sv
// Directed plus randomized bench for comp_inhibit against a pixel-level
// reference model.
module tb_comp_inhibit;
  localparam int CNT_W = 8;

  logic             sys_clk = 1'b0;
  logic             reset;
  logic             cnt_clr;
  logic [CNT_W-1:0] inh_cnt;

  comp_inhibit_if bus ();

  comp_inhibit #(.CNT_W(CNT_W)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus.slave),
    .cnt_clr (cnt_clr),
    .inh_cnt (inh_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic             m_valid;
  logic [7:0]       m_dbinh;
  logic             m_inh;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk pixels of width w bytes; a pixel matches if all its bytes match.
  function automatic logic [7:0] ref_dbinh(input logic [2:0] ps, input logic [7:0] dc,
                                           input logic en, input logic pm, input logic [2:0] pa);
    logic [7:0] r;
    int w, npix, pix, sel_pix;
    bit match;
    r = 8'h00;
    if (ps < 3'd3 || ps > 3'd5) return pm ? 8'h00 : 8'hFF;
    w = 1 << (int'(ps) - 3);
    npix = 8 / w;
    sel_pix = int'(pa) % npix;
    for (int l = 0; l < 8; l++) begin
      pix = l / w;
      match = 1'b1;
      for (int b = pix * w; b < pix * w + w; b++) match = match && dc[b];
      match = match && en;
      if (pm) r[l] = match;
      else    r[l] = (pix != sel_pix) || match;
    end
    return r;
  endfunction

  task automatic cycle(input logic vld, input logic [7:0] dc, input logic [2:0] ps,
                       input logic en, input logic pm, input logic [2:0] pa,
                       input logic ordy, input logic clr);
    logic exp_rdy, acc;
    logic [7:0] r;
    @(negedge sys_clk);
    bus.in_valid = vld; bus.dcomp = dc; bus.pixsize = ps; bus.dcompen = en;
    bus.phrase_mode = pm; bus.pixa = pa; bus.out_ready = ordy; cnt_clr = clr;
    #1;
    exp_rdy = !m_valid || ordy;
    chk("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    acc = vld && exp_rdy;
    r = ref_dbinh(ps, dc, en, pm, pa);
    if (clr) m_cnt = '0;
    else if (acc && r == 8'hFF && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (acc) begin
      m_dbinh = r; m_inh = (r == 8'hFF); m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge sys_clk); #1;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_valid});
    chk("dbinh", {24'b0, bus.dbinh}, {24'b0, m_dbinh});
    chk("inhibit", {31'b0, bus.inhibit}, {31'b0, m_inh});
    chk("inh_cnt", {{(32-CNT_W){1'b0}}, inh_cnt}, {{(32-CNT_W){1'b0}}, m_cnt});
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    reset = 1'b1;
    @(posedge sys_clk); #1;
    m_valid = 1'b0; m_dbinh = 8'h00; m_inh = 1'b0; m_cnt = '0;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_dbinh", {24'b0, bus.dbinh}, 32'd0);
    chk("rst_inhibit", {31'b0, bus.inhibit}, 32'd0);
    chk("rst_inh_cnt", {{(32-CNT_W){1'b0}}, inh_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge sys_clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cnt_clr = 1'b0;
    bus.in_valid = 1'b0; bus.dcomp = 8'h00; bus.pixsize = 3'd3; bus.dcompen = 1'b0;
    bus.phrase_mode = 1'b1; bus.pixa = 3'd0; bus.out_ready = 1'b1;
    do_reset();

    // 8bpp phrase
    cycle(1'b1, 8'hA5, 3'd3, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("tp_8bpp_dbinh", {24'b0, bus.dbinh}, 32'hA5);
    chk("tp_8bpp_cnt", {{(32-CNT_W){1'b0}}, inh_cnt}, 32'd0);
    // 16bpp phrase
    cycle(1'b1, 8'hF7, 3'd4, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("tp_16bpp_dbinh", {24'b0, bus.dbinh}, 32'hF3);
    cycle(1'b1, 8'hFF, 3'd4, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("tp_16bpp_inh", {31'b0, bus.inhibit}, 32'd1);
    chk("tp_16bpp_cnt", {{(32-CNT_W){1'b0}}, inh_cnt}, 32'd1);
    // 32bpp single pixel
    cycle(1'b1, 8'hF0, 3'd5, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
    chk("tp_32sp_a", {24'b0, bus.dbinh}, 32'hFF);
    cycle(1'b1, 8'h70, 3'd5, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
    chk("tp_32sp_b", {24'b0, bus.dbinh}, 32'h0F);
    cycle(1'b1, 8'h70, 3'd5, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    chk("tp_32sp_c", {24'b0, bus.dbinh}, 32'h0F);
    // drain
    cycle(1'b0, 8'h00, 3'd3, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("drain_hold", {24'b0, bus.dbinh}, 32'h0F);

    // backpressure
    cycle(1'b1, 8'h01, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    chk("bp_hold", {24'b0, bus.dbinh}, 32'h01);
    cycle(1'b1, 8'h02, 3'd3, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("bp_accept", {24'b0, bus.dbinh}, 32'h02);
    chk("bp_valid", {31'b0, bus.out_valid}, 32'd1);

    // counter saturation and clear priority
    for (int i = 0; i < (1 << CNT_W); i++)
      cycle(1'b1, 8'hFF, 3'd3, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("cnt_sat", {{(32-CNT_W){1'b0}}, inh_cnt}, (32'd1 << CNT_W) - 32'd1);
    cycle(1'b1, 8'hFF, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1);
    chk("cnt_clr", {{(32-CNT_W){1'b0}}, inh_cnt}, 32'd0);

    // reset while held
    cycle(1'b1, 8'h3C, 3'd3, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    do_reset();
    cycle(1'b1, 8'hFF, 3'd6, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("rsvd_phrase", {24'b0, bus.dbinh}, 32'h00);
    cycle(1'b1, 8'hFF, 3'd6, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
    chk("rsvd_single", {24'b0, bus.dbinh}, 32'hFF);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] ps;
      ps = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(3, 5)) : 3'($urandom_range(0, 7));
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), ps, 1'($urandom_range(0, 4) != 0),
            1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 30) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/comp_inhibit.md
Name: comp_inhibit

Overview:
- Registered stage directly downstream of the blitter data comparator.
- Consumes the eight per-byte equality flags (dcomp[0..7]) for one 64-bit phrase. Folds them into per-pixel matches according to pixel size.
- Produces a byte write-inhibit mask and a whole-write inhibit for the destination write path, with a one-entry valid/ready buffer and a saturating inhibit-event counter for debug.

Parameters:
- CNT_W, 16, width of inhibit-event counter

Ports:
- sys_clk  in  1  system clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- dcomp  in  8  byte-equality flags; bit i = byte lane i (lane 0 = patdlo[0:7] lane)
- in_valid  in  1  dcomp and controls valid this cycle
- in_ready  out  1  stage can accept; = !out_valid | out_ready
- pixsize  in  3  3=8bpp, 4=16bpp, 5=32bpp; others reserved
- dcompen  in  1  enable data-compare write inhibit
- phrase_mode  in  1  1=phrase write, 0=single-pixel write
- pixa  in  3  pixel index within phrase (single-pixel mode)
- dbinh  out  8  registered byte write inhibit, bit i = lane i, 1 = do not write
- inhibit  out  1  registered; 1 = entire write suppressed (dbinh == 8'hFF)
- out_valid  out  1  output registers hold an unconsumed result
- out_ready  in  1  downstream accepts result
- cnt_clr  in  1  synchronous clear of inh_cnt
- inh_cnt  out  CNT_W  number of accepted phrases with inhibit=1, saturating

Behaviour:
- Reset: out_valid=0, dbinh=8'h00, inhibit=0, inh_cnt=0. Reset mid-transfer discards the held result.
- Accept when in_valid & in_ready. On accept, the registers load the new result next edge and out_valid=1. Latency is 1 cycle.
- Hold when out_valid & !out_ready: dbinh, inhibit and out_valid are stable; in_ready=0.
- Drain when out_valid & out_ready & no accept: out_valid->0. dbinh and inhibit keep their last values.
- Simultaneous drain and accept: new result loads; out_valid stays 1; no bubble.
- Pixel match vector eqb[7:0], one bit per byte lane:
  - 8bpp: eqb[i] = dcomp[i].
  - 16bpp: for pair j, eqb[2j] = eqb[2j+1] = dcomp[2j] & dcomp[2j+1].
  - 32bpp: for quad k, all four lanes = AND of lanes 4k..4k+3.
  - Reserved pixsize: eqb = 8'h00, so no compare inhibit ever occurs.
- cmpmask = dcompen ? eqb : 8'h00.
- Phrase mode: dbinh = cmpmask.
- Single-pixel mode: selmask = lanes of the selected pixel.
  - 8bpp: lane pixa.
  - 16bpp: lanes 2*pixa[1:0] and +1.
  - 32bpp: lanes 4*pixa[0] to +3.
  - Reserved pixsize: selmask = 8'h00.
  - pixa bits above the needed width are ignored.
  - dbinh = ~selmask | (cmpmask & selmask).
- inhibit = (next dbinh == 8'hFF). This includes reserved pixsize in single-pixel mode (every lane inhibited).
- Counter: on accept with computed inhibit=1, inh_cnt increments by 1. It saturates at all-ones, with no wrap.
- cnt_clr has priority over a same-cycle increment; the result is 0.
- Counter is independent of out_ready.
- No combinational path from dcomp to any output; in_ready depends only on out_valid and out_ready.

Test Plan:
- Phrase, 8bpp, dcompen=1, dcomp=8'b1010_0101, out_ready=1 -> one cycle later out_valid=1, dbinh=8'hA5, inhibit=0, inh_cnt unchanged.
- Phrase, 16bpp, dcompen=1, dcomp=8'b1111_0111 -> dbinh=8'hF3 (pair 1 broken by lane 3), inhibit=0. Same with dcomp=8'hFF -> dbinh=8'hFF, inhibit=1, inh_cnt +1.
- Single-pixel, 32bpp, pixa=1, dcompen=1, dcomp=8'hF0 -> dbinh=8'hFF, inhibit=1. Then dcomp=8'h70 -> dbinh=8'h0F, inhibit=0. Then dcompen=0 -> dbinh=8'h0F.
- Backpressure: out_ready=0 with two back-to-back in_valid phrases (dcomp 8'h01, then 8'h02, 8bpp phrase) -> first held as dbinh=8'h01; in_ready=0 so second is not accepted. Raise out_ready -> same cycle in_ready=1, second accepted and dbinh=8'h02 next edge with out_valid continuously 1.
- Counter: preload by forcing 2^CNT_W−1 inhibit events, then one more -> stays at all-ones. Assert cnt_clr together with an inhibiting accept -> inh_cnt=0.
- Reset asserted while out_valid=1 and out_ready=0 -> next edge out_valid=0, dbinh=8'h00, inhibit=0, inh_cnt=0, in_ready=1. Reserved pixsize=6 phrase with dcomp=8'hFF -> dbinh=8'h00.
